// File: rtl/des_dispatch_ctrl.sv
// des_dispatch_ctrl: shares NUM_CORES des_block cores across one job stream.
// Issues consecutive seeds to idle cores round-robin and counts completions.
module des_dispatch_ctrl #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned SEED_W    = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [SEED_W-1:0]    job_seed,
    input  logic [CNT_W-1:0]     job_count,
    output logic [NUM_CORES-1:0] core_start,
    output logic [SEED_W-1:0]    core_seed,
    input  logic [NUM_CORES-1:0] core_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic [CNT_W-1:0]     done_cnt
);

    localparam int unsigned PTR_W = $clog2(NUM_CORES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]           state, state_d;
    logic [SEED_W-1:0]    seed_q, seed_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [PTR_W-1:0]     rr_ptr, rr_d;
    logic [CNT_W-1:0]     issued_d, done_cnt_d;
    logic [NUM_CORES-1:0] core_start_d;
    logic [SEED_W-1:0]    core_seed_d;
    logic                 job_ready_d, busy_d, done_d;

    logic                 found;
    logic [PTR_W-1:0]     grant_idx;
    int unsigned          idx;
    logic [NUM_CORES-1:0] hit;
    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     done_sum;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            seed_q     <= '0;
            count_q    <= '0;
            mask_q     <= '0;
            rr_ptr     <= '0;
            issued_cnt <= '0;
            done_cnt   <= '0;
            core_start <= '0;
            core_seed  <= '0;
            job_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            seed_q     <= seed_d;
            count_q    <= count_d;
            mask_q     <= mask_d;
            rr_ptr     <= rr_d;
            issued_cnt <= issued_d;
            done_cnt   <= done_cnt_d;
            core_start <= core_start_d;
            core_seed  <= core_seed_d;
            job_ready  <= job_ready_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Round-robin search for the first idle core at or after rr_ptr
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (!found) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NUM_CORES) idx = idx - NUM_CORES;
                if (!mask_q[PTR_W'(idx)]) begin
                    found     = 1'b1;
                    grant_idx = PTR_W'(idx);
                end
            end
        end
    end

    // Completions only count on cores we believe are busy
    always_comb begin
        hit     = core_valid & mask_q;
        hit_cnt = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hit[i]);
        end
        done_sum = done_cnt + hit_cnt;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        seed_d       = seed_q;
        count_d      = count_q;
        mask_d       = mask_q;
        rr_d         = rr_ptr;
        issued_d     = issued_cnt;
        done_cnt_d   = done_cnt;
        core_start_d = '0;
        core_seed_d  = core_seed;

        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    seed_d     = job_seed;
                    count_d    = job_count;
                    issued_d   = '0;
                    done_cnt_d = '0;
                    state_d    = (job_count == '0) ? S_DONE : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                mask_d     = mask_q & ~hit;
                done_cnt_d = done_sum;
                if ((issued_cnt < count_q) && found) begin
                    core_start_d[grant_idx] = 1'b1;
                    core_seed_d             = seed_q + SEED_W'(issued_cnt);
                    issued_d                = issued_cnt + CNT_W'(1);
                    mask_d[grant_idx]       = 1'b1;
                    if (32'(grant_idx) == NUM_CORES - 1) rr_d = '0;
                    else                                 rr_d = grant_idx + PTR_W'(1);
                end
                if (issued_d == count_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                mask_d     = mask_q & ~hit;
                done_cnt_d = done_sum;
                if (done_sum == count_q) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        job_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
        done_d      = (state == S_DONE);
    end

endmodule

// File: tb/tb_des_dispatch_ctrl.sv
// Directed bench for des_dispatch_ctrl with NUM_CORES=4.
module tb_des_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_seed;
    logic [31:0] job_count;
    logic [3:0]  core_start;
    logic [63:0] core_seed;
    logic [3:0]  core_valid;
    logic        busy;
    logic        done;
    logic [31:0] issued_cnt;
    logic [31:0] done_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    int          lat_cfg [4];
    int          exp_core[$];
    logic [63:0] exp_seed[$];

    des_dispatch_ctrl #(.NUM_CORES(4), .SEED_W(64), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_seed   (job_seed),
        .job_count  (job_count),
        .core_start (core_start),
        .core_seed  (core_seed),
        .core_valid (core_valid),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jv;
        logic [63:0] js;
        logic [31:0] jc;
        logic [3:0]  cv;
        logic [3:0]  e_start;
        logic [63:0] e_seed;
        logic        chk_seed;
        logic        e_ready;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_iss;
        logic [31:0] e_dc;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic r, logic jv, logic [63:0] js, logic [31:0] jc,
                                logic [3:0] cv, logic [3:0] es, logic [63:0] esd,
                                logic cs, logic er, logic eb, logic ed,
                                logic [31:0] ei, logic [31:0] edc);
        vec_t v;
        v.rst = r; v.jv = jv; v.js = js; v.jc = jc; v.cv = cv;
        v.e_start = es; v.e_seed = esd; v.chk_seed = cs;
        v.e_ready = er; v.e_busy = eb; v.e_done = ed; v.e_iss = ei; v.e_dc = edc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; job_valid = 1'b0; core_valid = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    // Run one job with a latency-per-core responder; expectations come from exp_core/exp_seed
    task automatic run_job(input string name, input logic [63:0] seed, input logic [31:0] cnt);
        bit pend [4];
        int pend_edge [4];
        int n_start = 0;
        int last_cv = -1000;
        int done_edge = -1;
        int done_pulses = 0;
        int acc;
        int ci;
        for (int c = 0; c < 4; c++) begin pend[c] = 0; pend_edge[c] = 0; end
        do_reset();
        job_valid = 1'b1; job_seed = seed; job_count = cnt;
        step();
        job_valid = 1'b0;
        acc = ecount;
        for (int t = 0; t < 400 && !(done_edge >= 0 && ecount > done_edge + 2); t++) begin
            core_valid = '0;
            for (int c = 0; c < 4; c++) begin
                if (pend[c] && ecount == pend_edge[c] + lat_cfg[c]) begin
                    core_valid[c] = 1'b1;
                    pend[c] = 0;
                    last_cv = ecount;
                end
            end
            step();
            if (core_start != '0) begin
                check({name, " start_onehot"}, 64'($onehot(core_start)), 64'd1);
                ci = 0;
                for (int c = 0; c < 4; c++) if (core_start[c]) ci = c;
                if (n_start < exp_core.size()) begin
                    check({name, " core"}, 64'(ci), 64'(exp_core[n_start]));
                    check({name, " seed"}, core_seed, exp_seed[n_start]);
                end
                if (n_start < 4) check({name, " start_edge"}, 64'(ecount), 64'(acc + 1 + n_start));
                pend[ci] = 1;
                pend_edge[ci] = ecount;
                n_start++;
            end
            if (done) begin
                done_pulses++;
                done_edge = ecount;
            end
        end
        core_valid = '0;
        check({name, " n_start"}, 64'(n_start), 64'(cnt));
        check({name, " done_pulses"}, 64'(done_pulses), 64'd1);
        check({name, " done_latency"}, 64'(done_edge), 64'(last_cv + 2));
        check({name, " issued_cnt"}, 64'(issued_cnt), 64'(cnt));
        check({name, " done_cnt"}, 64'(done_cnt), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_seed = '0; job_count = '0; core_valid = '0;

        //         rst jv seed   cnt cv       start    seed   chk rdy bsy dn iss dc
        vecs[0]  = mk(1, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  1, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  1, 1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 64'd10, 2, 4'b0000, 4'b0000, 64'd0,  0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0001, 64'd10, 1, 0, 1, 0, 1, 0);
        vecs[6]  = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0010, 64'd11, 1, 0, 1, 0, 2, 0);
        vecs[7]  = mk(0, 0, 64'd0,  0, 4'b0001, 4'b0000, 64'd0,  0, 0, 1, 0, 2, 1);
        vecs[8]  = mk(0, 0, 64'd0,  0, 4'b0100, 4'b0000, 64'd0,  0, 0, 1, 0, 2, 1);
        vecs[9]  = mk(0, 0, 64'd0,  0, 4'b0010, 4'b0000, 64'd0,  0, 0, 0, 0, 2, 2);
        vecs[10] = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  0, 1, 0, 1, 2, 2);
        vecs[11] = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  0, 1, 0, 0, 2, 2);
        vecs[12] = mk(0, 1, 64'd7,  0, 4'b0000, 4'b0000, 64'd0,  0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 64'd0,  0, 4'b0000, 4'b0000, 64'd0,  0, 1, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 64'd0,  0, 4'b1111, 4'b0000, 64'd0,  0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            rst = vecs[i].rst; job_valid = vecs[i].jv; job_seed = vecs[i].js;
            job_count = vecs[i].jc; core_valid = vecs[i].cv;
            step();
            check({tag, " core_start"}, 64'(core_start), 64'(vecs[i].e_start));
            if (vecs[i].chk_seed) check({tag, " core_seed"}, core_seed, vecs[i].e_seed);
            check({tag, " job_ready"}, 64'(job_ready), 64'(vecs[i].e_ready));
            check({tag, " busy"}, 64'(busy), 64'(vecs[i].e_busy));
            check({tag, " done"}, 64'(done), 64'(vecs[i].e_done));
            check({tag, " issued_cnt"}, 64'(issued_cnt), 64'(vecs[i].e_iss));
            check({tag, " done_cnt"}, 64'(done_cnt), 64'(vecs[i].e_dc));
        end
        job_valid = 1'b0; core_valid = '0;

        // Basic job: four cores started back to back
        for (int c = 0; c < 4; c++) lat_cfg[c] = 20;
        exp_core = '{0, 1, 2, 3};
        exp_seed = '{64'd0, 64'd1, 64'd2, 64'd3};
        run_job("basic", 64'd0, 32'd4);

        // Round-robin reuse: core 2 frees first, then core 0
        lat_cfg[0] = 10; lat_cfg[1] = 12; lat_cfg[2] = 5; lat_cfg[3] = 14;
        exp_core = '{0, 1, 2, 3, 2, 0};
        exp_seed = '{64'd100, 64'd101, 64'd102, 64'd103, 64'd104, 64'd105};
        run_job("rr", 64'd100, 32'd6);

        // Seed wraparound
        for (int c = 0; c < 4; c++) lat_cfg[c] = 3;
        exp_core = '{0, 1, 2};
        exp_seed = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        run_job("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 32'd3);

        // Simultaneous, spurious completions and job_valid while draining
        do_reset();
        job_valid = 1'b1; job_seed = 64'd0; job_count = 32'd4;
        step();
        job_valid = 1'b0;
        repeat (4) step();
        check("sim issued_cnt", 64'(issued_cnt), 64'd4);
        core_valid = 4'b1001; job_valid = 1'b1; job_seed = 64'd99; job_count = 32'd1;
        step();
        check("sim done_cnt_plus2", 64'(done_cnt), 64'd2);
        check("drain job_ready", 64'(job_ready), 64'd0);
        check("drain busy", 64'(busy), 64'd1);
        job_valid = 1'b0;
        step();
        check("spurious done_cnt", 64'(done_cnt), 64'd2);
        core_valid = 4'b0110;
        step();
        core_valid = '0;
        check("sim done_cnt_all", 64'(done_cnt), 64'd4);
        check("sim busy_off", 64'(busy), 64'd0);
        step();
        check("sim done_pulse", 64'(done), 64'd1);
        step();
        check("sim done_clear", 64'(done), 64'd0);
        check("sim issued_hold", 64'(issued_cnt), 64'd4);
        check("sim done_cnt_hold", 64'(done_cnt), 64'd4);

        // Reset in the middle of dispatch, then a fresh job
        do_reset();
        job_valid = 1'b1; job_seed = 64'd0; job_count = 32'd8;
        step();
        job_valid = 1'b0;
        repeat (2) step();
        check("midrst issued_before", 64'(issued_cnt), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst job_ready", 64'(job_ready), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst core_start", 64'(core_start), 64'd0);
        check("midrst core_seed", core_seed, 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst issued_cnt", 64'(issued_cnt), 64'd0);
        check("midrst done_cnt", 64'(done_cnt), 64'd0);
        job_valid = 1'b1; job_seed = 64'd5; job_count = 32'd1;
        step();
        job_valid = 1'b0;
        step();
        check("midrst new_start", 64'(core_start), 64'b0001);
        check("midrst new_seed", core_seed, 64'd5);
        core_valid = 4'b0011;
        step();
        core_valid = '0;
        check("midrst stale_dropped", 64'(done_cnt), 64'd1);
        step();
        check("midrst done", 64'(done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
